// File: rtl/aq32_uart_pkg.sv
// Shared definitions for the aq32 UART port: register map, STATUS/IRQ_EN bit
// positions, responder FSM encoding and the STATUS word packer.
package aq32_uart_pkg;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_DATA   = 2'd1,
    REG_IRQ_EN = 2'd2,
    REG_RSVD   = 2'd3
  } reg_addr_e;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_OVF   = 2;
  localparam int ST_RX_FERR  = 3;
  localparam int ST_TX_DROP  = 4;

  localparam int IE_RX_AVAIL = 0;
  localparam int IE_TX_READY = 1;
  localparam int IE_ERR      = 2;

  localparam logic [31:0] DATA_EMPTY_WORD = 32'h8000_0000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  function automatic logic [31:0] pack_status(input logic rx_avail, input logic tx_full,
                                              input logic ovf, input logic ferr,
                                              input logic drop);
    return {27'd0, drop, ferr, ovf, tx_full, rx_avail};
  endfunction

endpackage

// File: rtl/aq32_esp_uart_port.sv
// CPU-bus responder exposing the ESP UART TX/RX FIFOs as four word registers,
// with one-wait-state reads, TX back-pressure or drop, sticky errors and an IRQ.
module aq32_esp_uart_port
  import aq32_uart_pkg::*;
#(
  parameter bit TX_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wrdata,
  input  logic [3:0]  bus_bytesel,
  input  logic        bus_wren,
  input  logic        bus_strobe,
  output logic        bus_wait,
  output logic [31:0] bus_rddata,
  output logic        irq,
  output logic [8:0]  txfifo_data,
  output logic        txfifo_wr,
  input  logic        txfifo_full,
  input  logic [8:0]  rxfifo_data,
  output logic        rxfifo_rd,
  input  logic        rxfifo_empty,
  input  logic        rxfifo_overflow,
  input  logic        rx_framing_error
);

  state_e      state_q, state_d;
  logic [31:0] rddata_q, rddata_d;
  logic        irq_q, irq_d;
  logic [2:0]  irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic        ferr_q, ferr_d;
  logic        drop_q, drop_d;
  logic        rd_s, wr_s;
  logic        err_any_s;
  logic        unused_bits;

  assign unused_bits = ^{bus_wrdata[31:9], bus_bytesel[3:1]};
  assign err_any_s   = ovf_q | ferr_q | drop_q;
  assign txfifo_data = bus_wrdata[8:0];
  assign bus_rddata  = rddata_q;
  assign irq         = irq_q;
  // FIFO strobes are suppressed while reset is held so an aborted access never pops/pushes.
  assign rxfifo_rd   = rd_s & ~reset;
  assign txfifo_wr   = wr_s & ~reset;

  always_comb begin
    state_d  = state_q;
    rddata_d = rddata_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q | rxfifo_overflow;
    ferr_d   = ferr_q | rx_framing_error;
    drop_d   = drop_q;
    bus_wait = 1'b0;
    rd_s     = 1'b0;
    wr_s     = 1'b0;
    irq_d    = |(irq_en_q & {err_any_s, ~txfifo_full, ~rxfifo_empty});

    case (state_q)
      S_IDLE: begin
        if (bus_strobe && !bus_wren) begin
          bus_wait = 1'b1;
          state_d  = S_RESP;
          case (bus_addr)
            REG_STATUS: rddata_d = pack_status(~rxfifo_empty, txfifo_full, ovf_q, ferr_q, drop_q);
            REG_DATA: begin
              if (!rxfifo_empty) begin
                rddata_d = {1'b1, 22'd0, rxfifo_data};
                rd_s     = 1'b1;
              end else begin
                rddata_d = DATA_EMPTY_WORD;
              end
            end
            REG_IRQ_EN: rddata_d = {29'd0, irq_en_q};
            default:    rddata_d = 32'd0;
          endcase
        end else if (bus_strobe && bus_wren && bus_bytesel[0]) begin
          case (bus_addr)
            // A new error in the same cycle as its clear must survive, hence the OR after the mask.
            REG_STATUS: begin
              ovf_d  = (ovf_q  & ~bus_wrdata[ST_RX_OVF])  | rxfifo_overflow;
              ferr_d = (ferr_q & ~bus_wrdata[ST_RX_FERR]) | rx_framing_error;
              drop_d = drop_q & ~bus_wrdata[ST_TX_DROP];
            end
            REG_DATA: begin
              if (!txfifo_full) begin
                wr_s = 1'b1;
              end else if (TX_STALL) begin
                bus_wait = 1'b1;
              end else begin
                drop_d = 1'b1;
              end
            end
            REG_IRQ_EN: irq_en_d = bus_wrdata[2:0];
            default: irq_en_d = irq_en_q;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rddata_q <= 32'd0;
      irq_q    <= 1'b0;
      irq_en_q <= 3'd0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rddata_q <= rddata_d;
      irq_q    <= irq_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_aq32_esp_uart_port.sv
// Randomized and directed bench for aq32_esp_uart_port; dut1 stalls on TX full,
// dut0 drops. RX/TX FIFOs are modelled with queues, registers with a small model.
module tb_aq32_esp_uart_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [31:0] wrdata;
  logic [3:0]  be;
  logic        wren, strobe1, strobe0;
  logic        txfull, rxempty, ovf_in, ferr_in;
  logic [8:0]  rxdata;
  logic        wait1, irq1, txwr1, rxrd1, wait0, irq0, txwr0, rxrd0;
  logic [31:0] rdd1, rdd0;
  logic [8:0]  txd1, txd0;

  int n_cmp = 0, n_err = 0;
  int rd_cnt1 = 0, wr_cnt1 = 0, wr_cnt0 = 0;
  int full_timer = 0;
  bit force_full = 1'b0;
  logic irq_s;
  logic [8:0] rxq[$];
  logic [8:0] txq[$];
  logic [8:0] mq[$];
  logic [2:0] m_en;
  bit m_ovf, m_ferr;

  always #5 clk = ~clk;

  aq32_esp_uart_port #(.TX_STALL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus_addr(addr), .bus_wrdata(wrdata), .bus_bytesel(be),
    .bus_wren(wren), .bus_strobe(strobe1), .bus_wait(wait1), .bus_rddata(rdd1), .irq(irq1),
    .txfifo_data(txd1), .txfifo_wr(txwr1), .txfifo_full(txfull), .rxfifo_data(rxdata),
    .rxfifo_rd(rxrd1), .rxfifo_empty(rxempty), .rxfifo_overflow(ovf_in),
    .rx_framing_error(ferr_in));

  aq32_esp_uart_port #(.TX_STALL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus_addr(addr), .bus_wrdata(wrdata), .bus_bytesel(be),
    .bus_wren(wren), .bus_strobe(strobe0), .bus_wait(wait0), .bus_rddata(rdd0), .irq(irq0),
    .txfifo_data(txd0), .txfifo_wr(txwr0), .txfifo_full(txfull), .rxfifo_data(rxdata),
    .rxfifo_rd(rxrd0), .rxfifo_empty(rxempty), .rxfifo_overflow(ovf_in),
    .rx_framing_error(ferr_in));

  task automatic refresh();
    rxempty = (rxq.size() == 0);
    rxdata  = rxempty ? 9'd0 : rxq[0];
    txfull  = force_full || (full_timer > 0);
  endtask

  // One clock: sample at negedge, let the environment FIFOs react just after posedge.
  task automatic step(input bit use0, output logic w, output logic [31:0] rd);
    bit pop;
    @(negedge clk);
    w     = use0 ? wait0 : wait1;
    rd    = use0 ? rdd0 : rdd1;
    irq_s = irq1;
    pop   = rxrd1;
    if (rxrd1) rd_cnt1++;
    if (txwr1) begin wr_cnt1++; txq.push_back(txd1); end
    if (txwr0) wr_cnt0++;
    @(posedge clk); #1;
    if (pop && rxq.size() > 0) void'(rxq.pop_front());
    if (full_timer > 0) full_timer--;
    refresh();
  endtask

  task automatic idle(input int n);
    logic w; logic [31:0] r;
    strobe0 = 1'b0; strobe1 = 1'b0; wren = 1'b0;
    repeat (n) step(1'b0, w, r);
  endtask

  task automatic bus(input bit use0, input bit wr, input logic [1:0] a, input logic [31:0] wd,
                     input logic [3:0] b, output logic [31:0] rd, output int nw);
    logic w; logic [31:0] r; bit done;
    done = 1'b0; nw = 0; rd = 32'd0;
    addr = a; wrdata = wd; be = b; wren = wr;
    if (use0) strobe0 = 1'b1; else strobe1 = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      step(use0, w, r);
      if (!w) begin done = 1'b1; rd = r; end else nw++;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL bus_timeout: addr %0d still waiting after 60 cycles", a);
    end
    strobe0 = 1'b0; strobe1 = 1'b0; wren = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; strobe0 = 1'b0; strobe1 = 1'b0; wren = 1'b0;
    ovf_in = 1'b0; ferr_in = 1'b0;
    idle(3);
    reset = 1'b0;
    m_en = 3'd0; m_ovf = 1'b0; m_ferr = 1'b0;
  endtask

  function automatic logic [31:0] exp_status(input bit drop);
    return {27'd0, drop, m_ferr, m_ovf, txfull, (mq.size() != 0)};
  endfunction

  task automatic test_reset();
    logic [31:0] r; int nw;
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if ({wait1, rdd1, irq1, rxrd1, txwr1} !== 36'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", {wait1, rdd1, irq1, rxrd1, txwr1});
    end
    @(posedge clk); #1;
    bus(1'b0, 1'b0, 2'd0, 32'd0, 4'hF, r, nw);
    n_cmp++;
    if (r !== 32'd0 || nw != 1) begin
      n_err++; $display("FAIL reset_status: got %h/%0d waits expected 0/1", r, nw);
    end
  endtask

  task automatic test_rx_b2b();
    logic [31:0] r1, r2, r3; int nw, c0;
    rxq.push_back(9'h141); rxq.push_back(9'h022);
    mq.push_back(9'h141); mq.push_back(9'h022);
    refresh();
    c0 = rd_cnt1;
    bus(1'b0, 1'b0, 2'd1, 32'd0, 4'hF, r1, nw);
    bus(1'b0, 1'b0, 2'd1, 32'd0, 4'hF, r2, nw);
    n_cmp++;
    if (r1 !== 32'h8000_0141 || r2 !== 32'h8000_0022) begin
      n_err++; $display("FAIL rx_b2b_data: got %h %h expected 80000141 80000022", r1, r2);
    end
    n_cmp++;
    if (rd_cnt1 - c0 != 2) begin
      n_err++; $display("FAIL rx_b2b_pops: got %0d expected 2", rd_cnt1 - c0);
    end
    void'(mq.pop_front()); void'(mq.pop_front());
    bus(1'b0, 1'b0, 2'd1, 32'd0, 4'hF, r3, nw);
    n_cmp++;
    if (r3 !== 32'h8000_0000 || rd_cnt1 - c0 != 2) begin
      n_err++; $display("FAIL rx_empty_read: got %h pops %0d expected 80000000 pops 2", r3, rd_cnt1 - c0);
    end
  endtask

  task automatic test_tx_stall();
    logic [31:0] r; int nw, c0, q0;
    idle(1);
    c0 = wr_cnt1; q0 = txq.size();
    full_timer = 5; refresh();
    bus(1'b0, 1'b1, 2'd1, 32'h0000_01AB, 4'hF, r, nw);
    n_cmp++;
    if (nw != 5) begin
      n_err++; $display("FAIL tx_stall_waits: got %0d expected 5", nw);
    end
    n_cmp++;
    if (wr_cnt1 - c0 != 1 || txq.size() != q0 + 1) begin
      n_err++; $display("FAIL tx_stall_push: got %0d pushes expected 1", wr_cnt1 - c0);
    end else if (txq[txq.size()-1] !== 9'h1AB) begin
      n_err++; $display("FAIL tx_stall_data: got %h expected 1ab", txq[txq.size()-1]);
    end
  endtask

  task automatic test_tx_drop();
    logic [31:0] r; int nw, c0, c1;
    c0 = wr_cnt0; c1 = wr_cnt1;
    force_full = 1'b1; refresh();
    bus(1'b1, 1'b1, 2'd1, 32'h0000_0055, 4'hF, r, nw);
    n_cmp++;
    if (nw != 0 || wr_cnt0 != c0 || wr_cnt1 != c1) begin
      n_err++; $display("FAIL tx_drop_write: got waits %0d pushes %0d expected 0 0", nw, wr_cnt0 - c0);
    end
    bus(1'b1, 1'b0, 2'd0, 32'd0, 4'hF, r, nw);
    n_cmp++;
    if (r !== 32'h0000_0012) begin
      n_err++; $display("FAIL tx_drop_status: got %h expected 00000012", r);
    end
    bus(1'b1, 1'b1, 2'd0, 32'h0000_0010, 4'hF, r, nw);
    bus(1'b1, 1'b0, 2'd0, 32'd0, 4'hF, r, nw);
    n_cmp++;
    if (r !== 32'h0000_0002) begin
      n_err++; $display("FAIL tx_drop_clear: got %h expected 00000002", r);
    end
    force_full = 1'b0; refresh();
  endtask

  task automatic test_ferr_w1c();
    logic [31:0] r; logic w; int nw;
    ferr_in = 1'b1; idle(1); ferr_in = 1'b0;
    m_ferr = 1'b1;
    ferr_in = 1'b1;
    bus(1'b0, 1'b1, 2'd0, 32'h0000_0008, 4'hF, r, nw);
    ferr_in = 1'b0;
    bus(1'b0, 1'b0, 2'd0, 32'd0, 4'hF, r, nw);
    n_cmp++;
    if (r !== exp_status(1'b0)) begin
      n_err++; $display("FAIL ferr_set_wins: got %h expected %h", r, exp_status(1'b0));
    end
    bus(1'b0, 1'b1, 2'd2, 32'h0000_0004, 4'hF, r, nw);
    m_en = 3'd4;
    step(1'b0, w, r);
    n_cmp++;
    if (irq_s !== 1'b0) begin
      n_err++; $display("FAIL irq_err_early: got %b expected 0", irq_s);
    end
    step(1'b0, w, r);
    n_cmp++;
    if (irq_s !== 1'b1) begin
      n_err++; $display("FAIL irq_err: got %b expected 1", irq_s);
    end
    bus(1'b0, 1'b1, 2'd0, 32'h0000_001C, 4'hF, r, nw);
    bus(1'b0, 1'b1, 2'd2, 32'd0, 4'hF, r, nw);
    m_ferr = 1'b0; m_en = 3'd0;
  endtask

  task automatic test_irq_rx_reset();
    logic [31:0] r; logic w; int nw, c0;
    bus(1'b0, 1'b1, 2'd2, 32'h0000_0001, 4'hF, r, nw);
    m_en = 3'd1;
    idle(3);
    n_cmp++;
    if (irq_s !== 1'b0) begin
      n_err++; $display("FAIL irq_rx_idle: got %b expected 0", irq_s);
    end
    rxq.push_back(9'h0A5); mq.push_back(9'h0A5); refresh();
    idle(1);
    n_cmp++;
    if (irq_s !== 1'b0) begin
      n_err++; $display("FAIL irq_rx_latency: got %b expected 0", irq_s);
    end
    idle(1);
    n_cmp++;
    if (irq_s !== 1'b1) begin
      n_err++; $display("FAIL irq_rx_rise: got %b expected 1", irq_s);
    end
    c0 = rd_cnt1;
    addr = 2'd1; wren = 1'b0; be = 4'hF; strobe1 = 1'b1;
    step(1'b0, w, r);
    reset = 1'b1;
    step(1'b0, w, r); step(1'b0, w, r); step(1'b0, w, r);
    strobe1 = 1'b0; reset = 1'b0;
    void'(mq.pop_front());
    m_en = 3'd0; m_ovf = 1'b0; m_ferr = 1'b0;
    idle(2);
    n_cmp++;
    if (irq_s !== 1'b0 || rd_cnt1 - c0 != 1 || wait1 !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_read: got irq %b pops %0d wait %b expected 0 1 0", irq_s, rd_cnt1 - c0, wait1);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, wd, exp; logic [3:0] b; int nw, c0, op;
    logic [8:0] v;
    bit exp_irq;
    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 7);
      wd = $urandom(); b = 4'($urandom_range(0, 15));
      case (op)
        0: if (rxq.size() < 8) begin
             v = 9'($urandom_range(0, 511));
             rxq.push_back(v); mq.push_back(v); refresh();
           end
        1: begin
             c0 = rd_cnt1;
             exp = (mq.size() != 0) ? {1'b1, 22'd0, mq[0]} : 32'h8000_0000;
             bus(1'b0, 1'b0, 2'd1, wd, b, r, nw);
             n_cmp++;
             if (r !== exp || rd_cnt1 - c0 != ((mq.size() != 0) ? 1 : 0) || nw != 1) begin
               n_err++; $display("FAIL rnd_data_read: got %h pops %0d expected %h", r, rd_cnt1 - c0, exp);
             end
             if (mq.size() != 0) void'(mq.pop_front());
           end
        2: begin
             bus(1'b0, 1'b0, 2'd0, wd, b, r, nw);
             n_cmp++;
             if (r !== exp_status(1'b0)) begin
               n_err++; $display("FAIL rnd_status: got %h expected %h", r, exp_status(1'b0));
             end
           end
        3: begin
             bus(1'b0, 1'b1, 2'd2, wd, b, r, nw);
             if (b[0]) m_en = wd[2:0];
           end
        4: begin
             bus(1'b0, 1'b0, 2'd2, wd, b, r, nw);
             n_cmp++;
             if (r !== {29'd0, m_en}) begin
               n_err++; $display("FAIL rnd_irq_en: got %h expected %h", r, {29'd0, m_en});
             end
           end
        5: begin
             bus(1'b0, 1'b1, 2'd3, wd, b, r, nw);
             bus(1'b0, 1'b0, 2'd3, wd, b, r, nw);
             n_cmp++;
             if (r !== 32'd0) begin
               n_err++; $display("FAIL rnd_reserved: got %h expected 0", r);
             end
           end
        6: begin
             c0 = wr_cnt1;
             bus(1'b0, 1'b1, 2'd1, wd, b, r, nw);
             n_cmp++;
             if (wr_cnt1 - c0 != (b[0] ? 1 : 0) || nw != 0) begin
               n_err++; $display("FAIL rnd_tx_push: got %0d pushes expected %0d", wr_cnt1 - c0, b[0]);
             end else if (b[0] && txq[txq.size()-1] !== wd[8:0]) begin
               n_err++; $display("FAIL rnd_tx_data: got %h expected %h", txq[txq.size()-1], wd[8:0]);
             end
           end
        default: begin
             if (wd[31]) begin
               ovf_in = 1'b1; idle(1); ovf_in = 1'b0; m_ovf = 1'b1;
             end else if (wd[30]) begin
               ferr_in = 1'b1; idle(1); ferr_in = 1'b0; m_ferr = 1'b1;
             end
             bus(1'b0, 1'b1, 2'd0, wd, b, r, nw);
             if (b[0]) begin
               if (wd[2]) m_ovf = 1'b0;
               if (wd[3]) m_ferr = 1'b0;
             end
           end
      endcase
      idle(2);
      exp_irq = |(m_en & {(m_ovf | m_ferr), 1'b1, (mq.size() != 0)});
      n_cmp++;
      if (irq_s !== exp_irq) begin
        n_err++; $display("FAIL rnd_irq: got %b expected %b (op %0d)", irq_s, exp_irq, op);
      end
    end
  endtask

  initial begin
    reset = 1'b1; addr = 2'd0; wrdata = 32'd0; be = 4'd0; wren = 1'b0;
    strobe1 = 1'b0; strobe0 = 1'b0; ovf_in = 1'b0; ferr_in = 1'b0;
    refresh();
    #1;
    test_reset();
    test_tx_drop();
    test_rx_b2b();
    test_tx_stall();
    test_ferr_w1c();
    test_irq_rx_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
